// File: rtl/esc_frame_scheduler.sv
// Frame sequencer for the four quadcopter ESC PWM interfaces: periodic wrt strobe,
// double-buffered speed commands and the arming / idle-clamp / stale-command failsafe.
module esc_frame_scheduler #(
   parameter int unsigned FRAME_CLKS     = 125000,
   parameter int unsigned ARM_FRAMES     = 400,
   parameter int unsigned TIMEOUT_FRAMES = 8,
   parameter logic [10:0] IDLE_SPD       = 11'h050
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        arm,
   input  logic        vld,
   input  logic [10:0] frnt_cmd,
   input  logic [10:0] bck_cmd,
   input  logic [10:0] lft_cmd,
   input  logic [10:0] rght_cmd,
   output logic        wrt,
   output logic [10:0] frnt_spd,
   output logic [10:0] bck_spd,
   output logic [10:0] lft_spd,
   output logic [10:0] rght_spd,
   output logic        armed,
   output logic        fault
);

   localparam int CNT_W = $clog2(FRAME_CLKS);
   localparam int ARM_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
   localparam int STL_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);
   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_FRAMES - 1);
   localparam logic [STL_W-1:0] STL_LAST = STL_W'(TIMEOUT_FRAMES - 1);

   localparam logic [1:0] ST_DISARMED = 2'd0;
   localparam logic [1:0] ST_ARMING   = 2'd1;
   localparam logic [1:0] ST_RUN      = 2'd2;
   localparam logic [1:0] ST_FAULT    = 2'd3;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [STL_W-1:0] stale_q, stale_d;
   logic [1:0]       state_q, state_d;
   logic             wrt_q;
   logic             tick;
   logic             load_cmd;
   logic             preset_idle;
   logic [3:0][10:0] cmd_all;
   logic [3:0][10:0] spd_all;

   assign tick    = (cnt_q == CNT_LAST);
   assign cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
   assign cmd_all = {rght_cmd, lft_cmd, bck_cmd, frnt_cmd};

   always_comb begin
      state_d     = state_q;
      arm_cnt_d   = arm_cnt_q;
      stale_d     = stale_q;
      load_cmd    = 1'b0;
      preset_idle = 1'b0;
      case (state_q)
         ST_DISARMED: begin
            // Arming is only accepted on a frame boundary.
            if (tick && arm) begin
               state_d   = ST_ARMING;
               arm_cnt_d = '0;
            end
         end
         ST_ARMING: begin
            if (!arm) begin
               state_d = ST_DISARMED;
            end else if (tick) begin
               if (arm_cnt_q == ARM_LAST) begin
                  state_d     = ST_RUN;
                  preset_idle = 1'b1;
                  stale_d     = '0;
               end else begin
                  arm_cnt_d = arm_cnt_q + ARM_W'(1);
               end
            end
         end
         ST_RUN: begin
            load_cmd = vld;
            if (!arm) begin
               state_d = ST_DISARMED;
            end else if (vld) begin
               stale_d = '0;
            end else if (tick) begin
               if (stale_q == STL_LAST) begin
                  state_d = ST_FAULT;
               end else begin
                  stale_d = stale_q + STL_W'(1);
               end
            end
         end
         default: begin
            if (!arm) begin
               state_d = ST_DISARMED;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         arm_cnt_q <= '0;
         stale_q   <= '0;
         state_q   <= ST_DISARMED;
         wrt_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         arm_cnt_q <= arm_cnt_d;
         stale_q   <= stale_d;
         state_q   <= state_d;
         wrt_q     <= tick;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_motor
         logic [10:0] shadow_q, shadow_d;
         logic [10:0] spd_q;
         logic [10:0] frame_val;

         // Next-state view gives vld-on-tick bypass and zero on the launching edge of FAULT/DISARMED.
         always_comb begin
            shadow_d = shadow_q;
            if (preset_idle) begin
               shadow_d = IDLE_SPD;
            end else if (load_cmd) begin
               shadow_d = cmd_all[gi];
            end
            frame_val = 11'h000;
            if (state_d == ST_RUN) begin
               frame_val = (shadow_d < IDLE_SPD) ? IDLE_SPD : shadow_d;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow_q <= 11'h000;
               spd_q    <= 11'h000;
            end else begin
               shadow_q <= shadow_d;
               if (tick) begin
                  spd_q <= frame_val;
               end
            end
         end

         assign spd_all[gi] = spd_q;
      end
   endgenerate

   assign wrt      = wrt_q;
   assign frnt_spd = spd_all[0];
   assign bck_spd  = spd_all[1];
   assign lft_spd  = spd_all[2];
   assign rght_spd = spd_all[3];
   assign armed    = (state_q == ST_RUN);
   assign fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_esc_frame_scheduler.sv
// Bench for esc_frame_scheduler: frame-level vector table, hand-written corner sequences
// and a randomized run, all compared every cycle against a rule-level reference model.
module tb_esc_frame_scheduler;

   localparam int          FRAME = 100;
   localparam int          ARMF  = 3;
   localparam int          TOF   = 2;
   localparam logic [10:0] IDLE  = 11'h050;

   localparam int M_DIS    = 0;
   localparam int M_ARMING = 1;
   localparam int M_RUN    = 2;
   localparam int M_FAULT  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arm = 1'b0;
   logic        vld = 1'b0;
   logic [10:0] frnt_cmd = 11'h0;
   logic [10:0] bck_cmd = 11'h0;
   logic [10:0] lft_cmd = 11'h0;
   logic [10:0] rght_cmd = 11'h0;
   logic        wrt;
   logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
   logic        armed, fault;

   esc_frame_scheduler #(
      .FRAME_CLKS    (FRAME),
      .ARM_FRAMES    (ARMF),
      .TIMEOUT_FRAMES(TOF),
      .IDLE_SPD      (IDLE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .arm     (arm),
      .vld     (vld),
      .frnt_cmd(frnt_cmd),
      .bck_cmd (bck_cmd),
      .lft_cmd (lft_cmd),
      .rght_cmd(rght_cmd),
      .wrt     (wrt),
      .frnt_spd(frnt_spd),
      .bck_spd (bck_spd),
      .lft_spd (lft_spd),
      .rght_spd(rght_spd),
      .armed   (armed),
      .fault   (fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model state
   int          m_mode, m_count, m_armcnt, m_stale;
   logic [10:0] m_shadow [4];
   logic [10:0] m_spd [4];
   bit          m_wrt;

   typedef struct {
      bit               arm;
      int               vld_off;
      logic [3:0][10:0] cmd;
      logic [3:0][10:0] exp_spd;
      bit               exp_armed;
      bit               exp_fault;
   } vec_t;

   vec_t tbl [22];

   function automatic vec_t mk(bit a, int off,
                               logic [10:0] f, logic [10:0] b, logic [10:0] l, logic [10:0] r,
                               logic [10:0] ef, logic [10:0] eb, logic [10:0] el, logic [10:0] er,
                               bit ea, bit eflt);
      vec_t v;
      v.arm        = a;
      v.vld_off    = off;
      v.cmd        = {r, l, b, f};
      v.exp_spd    = {er, el, eb, ef};
      v.exp_armed  = ea;
      v.exp_fault  = eflt;
      return v;
   endfunction

   function automatic logic [10:0] max11(logic [10:0] a, logic [10:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_DIS;
      m_count  = 0;
      m_armcnt = 0;
      m_stale  = 0;
      m_wrt    = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_shadow[k] = 11'h0;
         m_spd[k]    = 11'h0;
      end
   endtask

   task automatic model_clock();
      logic [10:0] c [4];
      bit tick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      c[0] = frnt_cmd;
      c[1] = bck_cmd;
      c[2] = lft_cmd;
      c[3] = rght_cmd;
      tick    = (m_count == FRAME - 1);
      m_count = tick ? 0 : m_count + 1;
      m_wrt   = tick;
      if (m_mode == M_RUN && vld) begin
         for (int k = 0; k < 4; k++) m_shadow[k] = c[k];
      end
      case (m_mode)
         M_DIS: begin
            if (tick && arm) begin
               m_mode   = M_ARMING;
               m_armcnt = 0;
            end
         end
         M_ARMING: begin
            if (!arm) m_mode = M_DIS;
            else if (tick) begin
               m_armcnt++;
               if (m_armcnt == ARMF) begin
                  m_mode  = M_RUN;
                  m_stale = 0;
                  for (int k = 0; k < 4; k++) m_shadow[k] = IDLE;
               end
            end
         end
         M_RUN: begin
            if (!arm) m_mode = M_DIS;
            else if (vld) m_stale = 0;
            else if (tick) begin
               m_stale++;
               if (m_stale == TOF) m_mode = M_FAULT;
            end
         end
         default: begin
            if (!arm) m_mode = M_DIS;
         end
      endcase
      if (tick) begin
         for (int k = 0; k < 4; k++)
            m_spd[k] = (m_mode == M_RUN) ? max11(m_shadow[k], IDLE) : 11'h0;
      end
   endtask

   task automatic check_outputs();
      chk("wrt", 32'(wrt), 32'(m_wrt));
      chk("armed", 32'(armed), 32'(m_mode == M_RUN));
      chk("fault", 32'(fault), 32'(m_mode == M_FAULT));
      chk("frnt_spd", 32'(frnt_spd), 32'(m_spd[0]));
      chk("bck_spd", 32'(bck_spd), 32'(m_spd[1]));
      chk("lft_spd", 32'(lft_spd), 32'(m_spd[2]));
      chk("rght_spd", 32'(rght_spd), 32'(m_spd[3]));
   endtask

   // Inputs are driven before calling; DUT and model both consume them on the posedge.
   task automatic step();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      arm = v.arm;
      {rght_cmd, lft_cmd, bck_cmd, frnt_cmd} = v.cmd;
      for (int i = 0; i < FRAME; i++) begin
         vld = (i == v.vld_off);
         step();
      end
      vld = 1'b0;
      chk($sformatf("vec%0d_wrt", idx), 32'(wrt), 32'd1);
      chk($sformatf("vec%0d_frnt", idx), 32'(frnt_spd), 32'(v.exp_spd[0]));
      chk($sformatf("vec%0d_bck", idx), 32'(bck_spd), 32'(v.exp_spd[1]));
      chk($sformatf("vec%0d_lft", idx), 32'(lft_spd), 32'(v.exp_spd[2]));
      chk($sformatf("vec%0d_rght", idx), 32'(rght_spd), 32'(v.exp_spd[3]));
      chk($sformatf("vec%0d_armed", idx), 32'(armed), 32'(v.exp_armed));
      chk($sformatf("vec%0d_fault", idx), 32'(fault), 32'(v.exp_fault));
      $display("frame %0d: arm=%0d vld_off=%0d spd=%h/%h/%h/%h armed=%0d fault=%0d",
               idx, v.arm, v.vld_off, frnt_spd, bck_spd, lft_spd, rght_spd, armed, fault);
   endtask

   task automatic arm_to_run(input string tag);
      arm = 1'b1;
      vld = 1'b0;
      for (int i = 0; i < (ARMF + 1) * FRAME; i++) step();
      chk({tag, "_armed"}, 32'(armed), 32'd1);
      chk({tag, "_idle"}, 32'(frnt_spd), 32'(IDLE));
      $display("%s: reached RUN, spd=%h/%h/%h/%h", tag, frnt_spd, bck_spd, lft_spd, rght_spd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      int rate;

      tbl[0]  = mk(0, -1, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 0, 0);
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = mk(1, -1, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 0, 0);
      tbl[4]  = tbl[3];
      tbl[5]  = tbl[3];
      tbl[6]  = mk(1, -1, 11'h0, 11'h0, 11'h0, 11'h0, IDLE, IDLE, IDLE, IDLE, 1, 0);
      tbl[7]  = mk(1, 10, 11'h228, 11'h7FF, 11'h010, 11'h000, 11'h228, 11'h7FF, 11'h050, 11'h050, 1, 0);
      tbl[8]  = mk(1, 99, 11'h300, 11'h100, 11'h200, 11'h060, 11'h300, 11'h100, 11'h200, 11'h060, 1, 0);
      tbl[9]  = mk(1, 0, 11'h111, 11'h222, 11'h333, 11'h444, 11'h111, 11'h222, 11'h333, 11'h444, 1, 0);
      tbl[10] = mk(1, -1, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 0, 1);
      tbl[11] = mk(1, 20, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h0, 11'h0, 11'h0, 11'h0, 0, 1);
      tbl[12] = tbl[0];
      tbl[13] = tbl[3];
      tbl[14] = tbl[3];
      tbl[15] = tbl[3];
      tbl[16] = tbl[6];
      tbl[17] = tbl[0];
      tbl[18] = tbl[3];
      tbl[19] = tbl[3];
      tbl[20] = tbl[0];
      tbl[21] = tbl[0];

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      chk("reset_wrt", 32'(wrt), 32'd0);
      chk("reset_spd", 32'({frnt_spd, bck_spd, lft_spd, rght_spd}), 32'd0);
      chk("reset_armed", 32'(armed), 32'd0);
      chk("reset_fault", 32'(fault), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) run_frame(tbl[i], i);

      // arm dropped in the middle of a RUN frame: in-flight value holds until the next launch
      arm_to_run("seqA");
      for (int i = 0; i < 50; i++) step();
      arm = 1'b0;
      step();
      chk("seqA_drop_armed", 32'(armed), 32'd0);
      chk("seqA_inflight_spd", 32'(frnt_spd), 32'(IDLE));
      for (int i = 0; i < FRAME - 51; i++) step();
      chk("seqA_launch_wrt", 32'(wrt), 32'd1);
      chk("seqA_launch_spd", 32'(rght_spd), 32'd0);
      $display("seqA: arm drop mid-RUN, next frame spd=%h", rght_spd);

      // asynchronous reset at count 50 while running
      arm_to_run("seqB");
      for (int i = 0; i < 50; i++) step();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("seqB_rst_spd", 32'(frnt_spd), 32'd0);
      chk("seqB_rst_armed", 32'(armed), 32'd0);
      chk("seqB_rst_wrt", 32'(wrt), 32'd0);
      arm = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      waited = 0;
      for (int i = 1; i <= 150; i++) begin
         step();
         waited = i;
         if (wrt === 1'b1) break;
      end
      chk("seqB_first_wrt_delay", 32'(waited), 32'(FRAME));
      $display("seqB: first wrt %0d cycles after reset release", waited);

      // randomized run against the model
      arm  = 1'b1;
      rate = 20;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (cyc % 500 == 0) begin
            case ($urandom_range(0, 2))
               0:       rate = 20;
               1:       rate = 120;
               default: rate = 400;
            endcase
         end
         if (arm ? ($urandom_range(0, 1499) == 0) : ($urandom_range(0, 149) == 0)) arm = ~arm;
         vld = ($urandom_range(0, rate - 1) == 0);
         if ($urandom_range(0, 1) == 1) begin
            frnt_cmd = 11'($urandom_range(0, 2047));
            bck_cmd  = 11'($urandom_range(0, 2047));
            lft_cmd  = 11'($urandom_range(0, 2047));
            rght_cmd = 11'($urandom_range(0, 2047));
         end else begin
            frnt_cmd = 11'($urandom_range(0, 160));
            bck_cmd  = 11'($urandom_range(0, 160));
            lft_cmd  = 11'($urandom_range(0, 160));
            rght_cmd = 11'($urandom_range(0, 160));
         end
         rst_n = ($urandom_range(0, 4999) != 0);
         step();
         if (wrt === 1'b1)
            $display("rand cyc %0d: spd=%h/%h/%h/%h armed=%0d fault=%0d",
                     cyc, frnt_spd, bck_spd, lft_spd, rght_spd, armed, fault);
      end
      rst_n = 1'b1;
      vld   = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/esc_frame_scheduler.md
Name: esc_frame_scheduler

Overview:
- Sequences the four ESC PWM interfaces (front, back, left, right) of the quadcopter.
- Generates the periodic one-cycle wrt strobe that launches each PWM frame.
- Double-buffers the four 11-bit speed commands from the flight controller and presents them stable on the frame edge.
- Enforces arming, idle-clamp and stale-command failsafe policy, so each ESC interface only ever sees a legal SPEED with a synchronous wrt.

Parameters:
FRAME_CLKS, 125000, clocks per PWM frame (400 Hz at 50 MHz); must exceed the maximum ESC pulse of 12391 clks.
ARM_FRAMES, 400, frames of zero-speed pulses required before RUN.
TIMEOUT_FRAMES, 8, consecutive frames without vld in RUN that trigger FAULT.
IDLE_SPD, 11'h050, minimum speed applied to every motor while in RUN.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
arm  input  1  level; 1 requests armed operation, 0 disarms
vld  input  1  one-cycle strobe; the four *_cmd inputs are valid
frnt_cmd  input  11  front motor speed command
bck_cmd  input  11  back motor speed command
lft_cmd  input  11  left motor speed command
rght_cmd  input  11  right motor speed command
wrt  output  1  one-cycle frame strobe to all four ESC interfaces
frnt_spd  output  11  registered SPEED to front ESC interface
bck_spd  output  11  registered SPEED to back ESC interface
lft_spd  output  11  registered SPEED to left ESC interface
rght_spd  output  11  registered SPEED to right ESC interface
armed  output  1  1 while state is RUN
fault  output  1  1 while state is FAULT

Behaviour:
- Reset (async, rst_n=0):
  - state=DISARMED; frame counter=0; arm and stale counters=0; shadow registers=0.
  - wrt=0, all *_spd=0, armed=0, fault=0.
- Frame counter:
  - Free-runs 0..FRAME_CLKS-1 in every state; tick = (count==FRAME_CLKS-1).
  - On the edge after tick, the counter wraps to 0, wrt=1 for exactly that one cycle, and all four *_spd load their new frame values on that same edge.
  - *_spd change only on wrt edges, so SPEED is stable whenever wrt=1. First wrt occurs FRAME_CLKS cycles after reset release.
- Shadow capture:
  - A vld in RUN loads all four cmds into the shadows atomically.
  - vld on the tick cycle: the new cmds are used for the frame launched on the next edge (bypass, not delayed one frame).
  - vld outside RUN is ignored.
- Frame value selection:
  - DISARMED, ARMING, FAULT: 0.
  - RUN: max(shadow, IDLE_SPD) per motor (unsigned 11-bit compare, no other arithmetic).
- DISARMED:
  - arm=1 sampled on a tick -> ARMING, arm counter cleared.
  - arm is not acted on between ticks, so arming aligns to a frame.
- ARMING:
  - arm counter increments on each tick.
  - Tick with counter==ARM_FRAMES-1 -> RUN; shadows preset to IDLE_SPD, stale counter cleared.
  - The first RUN frame value is therefore IDLE_SPD on all motors.
- RUN:
  - Stale counter clears on any vld, otherwise increments on each tick.
  - Tick on which the counter would reach TIMEOUT_FRAMES -> FAULT (that frame launches with 0).
  - vld and tick in the same cycle counts as fresh.
- arm=0 in ARMING or RUN -> DISARMED on the next edge, regardless of tick.
  - Zero speeds take effect at the next frame launch; a pulse already in flight is not truncated.
- FAULT:
  - fault=1; speeds 0; vld ignored.
  - Exit only via arm=0 -> DISARMED; fault clears on that edge.
  - Holding arm=1 never re-arms from FAULT.
- Reset mid-frame: all state discarded immediately; frame timing restarts from count 0.
- wrt continues every frame in all states, so ESCs always receive 0-speed keep-alive pulses.

Test Plan (FRAME_CLKS=100, ARM_FRAMES=3, TIMEOUT_FRAMES=2, IDLE_SPD=11'h050):
- Reset release, arm=0 -> wrt high for exactly 1 clk at cycles 100, 200, 300; all *_spd=0; armed=0; fault=0.
- arm=1 held -> 3 wrt pulses at speed 0, then armed=1; first RUN frame has all *_spd=11'h050.
- In RUN, vld with frnt=11'h228, bck=11'h7FF, lft=11'h010, rght=0 -> next wrt edge gives 11'h228, 11'h7FF, 11'h050, 11'h050; values hold constant between wrt pulses.
- vld coincident with tick carrying frnt=11'h300 -> launched frame shows 11'h300; vld one cycle after tick -> change appears one frame later.
- In RUN, no vld for 2 ticks -> fault=1, armed=0, subsequent frames 0; vld ignored; arm=0 -> DISARMED with fault=0; arm=1 again -> full 3-frame arming sequence repeats.
- arm dropped mid-ARMING and mid-RUN, plus rst_n asserted at count=50 -> DISARMED next edge, 0 speeds at next frame, counter restarts at 0 after reset.
